// File: rtl/tartaruga_pkg.sv
// tartaruga_pkg: shared core types and constants.
// Holds the reorder-buffer geometry, the exception vector, the decode/writeback
// payload structs and the reorder-buffer entry layout used by rob_commit.
package tartaruga_pkg;

  localparam int          ROB_SIZE     = 16;
  localparam int          ROB_IDX_BITS = $clog2(ROB_SIZE);
  localparam logic [31:0] ADDR_XCPT    = 32'h0000_2000;

  typedef logic [31:0]             bus32_t;
  typedef logic [4:0]              reg_addr_t;
  typedef logic [3:0]              xcpt_code_t;
  typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;
  // Pointer with an extra wrap bit so full and empty are distinguishable.
  typedef logic [ROB_IDX_BITS:0]   rob_ptr_t;

  typedef struct packed {
    bus32_t     pc;
    bus32_t     instr;
    reg_addr_t  addr_rd;
    logic       write_enable;
    logic       store_to_mem;
    bus32_t     kanata_id;
    logic       xcpt;
    xcpt_code_t xcpt_code;
    rob_idx_t   rob_idx;
  } instr_data_t;

  typedef struct packed {
    instr_data_t instr;
    bus32_t      result;
    logic        branch_taken;
    bus32_t      branched_pc;
  } mem_to_wb_t;

  typedef struct packed {
    logic       valid;
    logic       completed;
    bus32_t     pc;
    bus32_t     instr;
    reg_addr_t  addr_rd;
    logic       write_enable;
    logic       store_to_mem;
    bus32_t     kanata_id;
    logic       xcpt;
    xcpt_code_t xcpt_code;
    bus32_t     result;
    logic       branch_taken;
    bus32_t     new_pc;
  } rob_entry_t;

  // Sequential successor of a PC; the default redirect target of an entry.
  function automatic bus32_t next_seq_pc(input bus32_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with in-order retirement.
// Decode allocates at the tail, writeback marks entries completed out of order,
// and the oldest entry retires once completed. A retiring entry carrying an
// exception squashes every entry and redirects fetch to ADDR_XCPT.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   alloc_valid_i/alloc_data_i       allocation request and decoded instruction
//   alloc_ready_o/alloc_idx_o        not-full indication, tail index handed out
//   complete_valid_i/complete_data_i writeback result, target instr.rob_idx
//   commit_valid_o/commit_entry_o    head entry retiring this cycle
//   rf_we_o/rf_addr_o/rf_data_o      register-file write port
//   store_commit_o                   retiring store may be performed
//   flush_o/flush_pc_o               exception squash and redirect PC
//   count_o                          occupied entries
module rob_commit
  import tartaruga_pkg::*;
#(
  parameter int ROB_SIZE = tartaruga_pkg::ROB_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       alloc_valid_i,
  input  instr_data_t                alloc_data_i,
  output logic                       alloc_ready_o,
  output rob_idx_t                   alloc_idx_o,
  input  logic                       complete_valid_i,
  input  mem_to_wb_t                 complete_data_i,
  output logic                       commit_valid_o,
  output rob_entry_t                 commit_entry_o,
  output logic                       rf_we_o,
  output reg_addr_t                  rf_addr_o,
  output bus32_t                     rf_data_o,
  output logic                       store_commit_o,
  output logic                       flush_o,
  output bus32_t                     flush_pc_o,
  output logic [$clog2(ROB_SIZE):0]  count_o
);

  localparam int                IDX_BITS   = $clog2(ROB_SIZE);
  localparam logic [IDX_BITS:0] FULL_COUNT = (IDX_BITS+1)'(ROB_SIZE);

  rob_entry_t            entries_r [ROB_SIZE];
  logic [IDX_BITS:0]     head_r;
  logic [IDX_BITS:0]     tail_r;

  logic [IDX_BITS:0]     count_s;
  logic                  full_s;
  logic [IDX_BITS-1:0]   head_idx_s;
  logic [IDX_BITS-1:0]   tail_idx_s;
  logic [IDX_BITS-1:0]   comp_idx_s;
  rob_entry_t            head_entry_s;
  rob_entry_t            comp_target_s;
  rob_entry_t            alloc_entry_s;
  rob_entry_t            comp_entry_s;
  logic                  commit_s;
  logic                  flush_s;
  logic                  alloc_fire_s;
  logic                  comp_fire_s;

  assign count_s       = tail_r - head_r;
  assign full_s        = (count_s == FULL_COUNT);
  assign head_idx_s    = head_r[IDX_BITS-1:0];
  assign tail_idx_s    = tail_r[IDX_BITS-1:0];
  assign comp_idx_s    = complete_data_i.instr.rob_idx[IDX_BITS-1:0];
  assign head_entry_s  = entries_r[head_idx_s];
  assign comp_target_s = entries_r[comp_idx_s];

  assign commit_s      = head_entry_s.valid && head_entry_s.completed;
  assign flush_s       = commit_s && head_entry_s.xcpt;
  // Ready depends on registered state only; the flush term gates the fire.
  assign alloc_fire_s  = alloc_valid_i && !full_s && !flush_s;
  // Late or duplicate completions (invalid or already completed) are dropped.
  assign comp_fire_s   = complete_valid_i && comp_target_s.valid &&
                         !comp_target_s.completed && !flush_s;

  // Build the entry written at the tail on allocation.
  always_comb begin
    alloc_entry_s              = '0;
    alloc_entry_s.valid        = 1'b1;
    // Fetch/decode exceptions never execute, so they are ready to retire.
    alloc_entry_s.completed    = alloc_data_i.xcpt;
    alloc_entry_s.pc           = alloc_data_i.pc;
    alloc_entry_s.instr        = alloc_data_i.instr;
    alloc_entry_s.addr_rd      = alloc_data_i.addr_rd;
    alloc_entry_s.write_enable = alloc_data_i.write_enable;
    alloc_entry_s.store_to_mem = alloc_data_i.store_to_mem;
    alloc_entry_s.kanata_id    = alloc_data_i.kanata_id;
    alloc_entry_s.xcpt         = alloc_data_i.xcpt;
    alloc_entry_s.xcpt_code    = alloc_data_i.xcpt_code;
    alloc_entry_s.result       = 32'd0;
    alloc_entry_s.branch_taken = 1'b0;
    alloc_entry_s.new_pc       = next_seq_pc(alloc_data_i.pc);
  end

  // Merge a writeback result into its target entry.
  always_comb begin
    comp_entry_s              = comp_target_s;
    comp_entry_s.completed    = 1'b1;
    comp_entry_s.result       = complete_data_i.result;
    comp_entry_s.branch_taken = complete_data_i.branch_taken;
    if (complete_data_i.branch_taken) begin
      comp_entry_s.new_pc = complete_data_i.branched_pc;
    end else begin
      comp_entry_s.new_pc = comp_target_s.new_pc;
    end
    // Exceptions raised in execution join any already recorded at decode.
    comp_entry_s.xcpt      = comp_target_s.xcpt | complete_data_i.instr.xcpt;
    comp_entry_s.xcpt_code = comp_target_s.xcpt_code | complete_data_i.instr.xcpt_code;
  end

  // Entry storage and head/tail pointers; reset, then flush, then normal updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_r <= '0;
      tail_r <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_r[i].valid <= 1'b0;
      end
    end else if (flush_s) begin
      head_r <= '0;
      tail_r <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_r[i].valid <= 1'b0;
      end
    end else begin
      // The three write targets never alias: alloc hits an invalid slot,
      // completion an uncompleted valid one, commit a completed head.
      if (commit_s) begin
        entries_r[head_idx_s].valid <= 1'b0;
        head_r <= head_r + {{IDX_BITS{1'b0}}, 1'b1};
      end
      if (alloc_fire_s) begin
        entries_r[tail_idx_s] <= alloc_entry_s;
        tail_r <= tail_r + {{IDX_BITS{1'b0}}, 1'b1};
      end
      if (comp_fire_s) begin
        entries_r[comp_idx_s] <= comp_entry_s;
      end
    end
  end

  // Retirement side effects of the head entry.
  always_comb begin
    commit_valid_o = commit_s;
    commit_entry_o = head_entry_s;
    rf_addr_o      = head_entry_s.addr_rd;
    rf_data_o      = head_entry_s.result;
    flush_o        = flush_s;
    if (commit_s && !head_entry_s.xcpt) begin
      rf_we_o        = head_entry_s.write_enable && (head_entry_s.addr_rd != 5'd0);
      store_commit_o = head_entry_s.store_to_mem;
    end else begin
      rf_we_o        = 1'b0;
      store_commit_o = 1'b0;
    end
  end

  assign alloc_ready_o = !full_s;
  assign alloc_idx_o   = rob_idx_t'(tail_idx_s);
  assign count_o       = count_s;
  assign flush_pc_o    = ADDR_XCPT;

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  import tartaruga_pkg::*;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  instr_data_t alloc_data;
  logic        alloc_ready;
  rob_idx_t    alloc_idx;
  logic        complete_valid;
  mem_to_wb_t  complete_data;
  logic        commit_valid;
  rob_entry_t  commit_entry;
  logic        rf_we;
  reg_addr_t   rf_addr;
  bus32_t      rf_data;
  logic        store_commit;
  logic        flush;
  bus32_t      flush_pc;
  logic [4:0]  count;

  int errors = 0;
  int checks = 0;

  rob_commit #(.ROB_SIZE(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_data_i(alloc_data),
    .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
    .complete_valid_i(complete_valid), .complete_data_i(complete_data),
    .commit_valid_o(commit_valid), .commit_entry_o(commit_entry),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .store_commit_o(store_commit), .flush_o(flush), .flush_pc_o(flush_pc),
    .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instructions in program order, oldest first.
  typedef struct {
    int          idx;
    bit          done;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          we;
    bit          st;
    bit          xcpt;
    logic [31:0] result;
    logic [31:0] new_pc;
  } m_ent_t;

  m_ent_t q[$];
  int     m_tail = 0;  // allocation sequence number modulo 2*16

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_data_t mk_instr(input logic [31:0] pc, input logic [4:0] rd,
                                           input bit we, input bit st, input bit xc);
    instr_data_t d;
    d              = '0;
    d.pc           = pc;
    d.instr        = 32'h0000_0013;
    d.addr_rd      = rd;
    d.write_enable = we;
    d.store_to_mem = st;
    d.kanata_id    = pc;
    d.xcpt         = xc;
    d.xcpt_code    = xc ? 4'h1 : 4'h0;
    return d;
  endfunction

  function automatic mem_to_wb_t mk_comp(input int idx, input logic [31:0] res, input bit xc,
                                         input bit tk, input logic [31:0] bpc);
    mem_to_wb_t c;
    c                   = '0;
    c.instr.rob_idx     = rob_idx_t'(idx);
    c.instr.xcpt        = xc;
    c.instr.xcpt_code   = xc ? 4'h2 : 4'h0;
    c.result            = res;
    c.branch_taken      = tk;
    c.branched_pc       = bpc;
    return c;
  endfunction

  // Compare every DUT output against what the model predicts for this cycle.
  task automatic check_model();
    bit cv;
    cv = (q.size() > 0) && q[0].done;
    chk("count", 64'(count), 64'(q.size()));
    chk("alloc_ready", 64'(alloc_ready), 64'(q.size() < 16));
    chk("alloc_idx", 64'(alloc_idx), 64'(m_tail % 16));
    chk("commit_valid", 64'(commit_valid), 64'(cv));
    chk("flush_pc", 64'(flush_pc), 64'(32'h0000_2000));
    if (cv) begin
      chk("flush", 64'(flush), 64'(q[0].xcpt));
      chk("rf_we", 64'(rf_we), 64'(!q[0].xcpt && q[0].we && (q[0].rd != 5'd0)));
      chk("store_commit", 64'(store_commit), 64'(!q[0].xcpt && q[0].st));
      chk("commit_pc", 64'(commit_entry.pc), 64'(q[0].pc));
      if (!q[0].xcpt) begin
        chk("rf_addr", 64'(rf_addr), 64'(q[0].rd));
        chk("rf_data", 64'(rf_data), 64'(q[0].result));
        chk("new_pc", 64'(commit_entry.new_pc), 64'(q[0].new_pc));
      end
    end else begin
      chk("flush_idle", 64'(flush), 64'(1'b0));
      chk("rf_we_idle", 64'(rf_we), 64'(1'b0));
      chk("store_idle", 64'(store_commit), 64'(1'b0));
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    int  pre_size;
    bit  did_commit;
    m_ent_t e;
    pre_size = q.size();
    if (rst) begin
      q.delete();
      m_tail = 0;
    end else if (pre_size > 0 && q[0].done && q[0].xcpt) begin
      q.delete();
      m_tail = 0;
    end else begin
      did_commit = (pre_size > 0) && q[0].done;
      if (complete_valid) begin
        foreach (q[i]) begin
          if (q[i].idx == int'(complete_data.instr.rob_idx) && !q[i].done) begin
            q[i].done   = 1'b1;
            q[i].result = complete_data.result;
            q[i].xcpt   = q[i].xcpt | complete_data.instr.xcpt;
            if (complete_data.branch_taken) q[i].new_pc = complete_data.branched_pc;
          end
        end
      end
      if (did_commit) void'(q.pop_front());
      if (alloc_valid && pre_size < 16) begin
        e.idx    = m_tail % 16;
        e.done   = alloc_data.xcpt;
        e.pc     = alloc_data.pc;
        e.rd     = alloc_data.addr_rd;
        e.we     = alloc_data.write_enable;
        e.st     = alloc_data.store_to_mem;
        e.xcpt   = alloc_data.xcpt;
        e.result = 32'd0;
        e.new_pc = alloc_data.pc + 32'd4;
        q.push_back(e);
        m_tail = (m_tail + 1) % 32;
      end
    end
  endtask

  task automatic settle();
    #4;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst            = 1'b0;
    alloc_valid    = 1'b0;
    complete_valid = 1'b0;
    alloc_data     = '0;
    complete_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #4;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    settle();
    chk("rst_ready", 64'(alloc_ready), 64'(1'b1));
    chk("rst_count", 64'(count), 64'(5'd0));
    chk("rst_commit", 64'(commit_valid), 64'(1'b0));
    chk("rst_flush", 64'(flush), 64'(1'b0));
    tick();

    // Single addi x5 round trip.
    alloc_valid = 1'b1;
    alloc_data  = mk_instr(32'h100, 5'd5, 1'b1, 1'b0, 1'b0);
    settle();
    chk("addi_idx", 64'(alloc_idx), 64'(4'd0));
    tick();
    alloc_valid    = 1'b0;
    complete_valid = 1'b1;
    complete_data  = mk_comp(0, 32'h2A, 1'b0, 1'b0, 32'h0);
    settle();
    tick();
    complete_valid = 1'b0;
    settle();
    chk("addi_we", 64'(rf_we), 64'(1'b1));
    chk("addi_rd", 64'(rf_addr), 64'(5'd5));
    chk("addi_data", 64'(rf_data), 64'(32'h2A));
    tick();
    settle();
    chk("addi_count", 64'(count), 64'(5'd0));
    tick();

    // Out-of-order completion, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_data  = mk_instr(32'h200 + 32'(i * 4), 5'(i + 1), 1'b1, 1'b0, 1'b0);
      settle();
      tick();
    end
    alloc_valid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      complete_valid = 1'b1;
      complete_data  = mk_comp(i, 32'(100 + i), 1'b0, 1'b0, 32'h0);
      settle();
      chk("ooo_nocommit", 64'(commit_valid), 64'(1'b0));
      tick();
    end
    complete_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ooo_order", 64'(rf_data), 64'(100 + i));
      tick();
    end

    // Fill to full, then drain one and observe the wrapped tail.
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      alloc_data = mk_instr(32'h1000 + 32'(i * 4), 5'd7, 1'b1, 1'b0, 1'b0);
      settle();
      tick();
    end
    alloc_data     = mk_instr(32'h3000, 5'd8, 1'b1, 1'b0, 1'b0);
    complete_valid = 1'b1;
    complete_data  = mk_comp(0, 32'h55, 1'b0, 1'b0, 32'h0);
    settle();
    chk("full_ready", 64'(alloc_ready), 64'(1'b0));
    chk("full_count", 64'(count), 64'(5'd16));
    tick();
    complete_valid = 1'b0;
    settle();
    chk("full_commit", 64'(commit_valid), 64'(1'b1));
    tick();
    settle();
    chk("wrap_ready", 64'(alloc_ready), 64'(1'b1));
    chk("wrap_idx", 64'(alloc_idx), 64'(4'd0));
    tick();
    alloc_valid = 1'b0;
    settle();
    chk("wrap_count", 64'(count), 64'(5'd16));
    tick();

    // Exception retire flushes younger entries.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_data  = mk_instr(32'h400 + 32'(i * 4), 5'(i + 1), 1'b1, 1'b0, 1'b0);
      settle();
      tick();
    end
    alloc_valid    = 1'b0;
    complete_valid = 1'b1;
    complete_data  = mk_comp(1, 32'h11, 1'b1, 1'b0, 32'h0);
    settle();
    tick();
    complete_data = mk_comp(0, 32'h7, 1'b0, 1'b0, 32'h0);
    settle();
    tick();
    complete_valid = 1'b0;
    settle();
    chk("xc_first", 64'(rf_data), 64'(32'h7));
    chk("xc_first_flush", 64'(flush), 64'(1'b0));
    tick();
    complete_valid = 1'b1;
    complete_data  = mk_comp(2, 32'h99, 1'b0, 1'b0, 32'h0);
    settle();
    chk("xc_flush", 64'(flush), 64'(1'b1));
    chk("xc_pc", 64'(flush_pc), 64'(32'h2000));
    chk("xc_we", 64'(rf_we), 64'(1'b0));
    tick();
    settle();
    chk("xc_count", 64'(count), 64'(5'd0));
    tick();
    complete_valid = 1'b0;
    settle();
    chk("xc_stale", 64'(commit_valid), 64'(1'b0));
    tick();

    // Store to x0 and write to x0.
    do_reset();
    alloc_valid = 1'b1;
    alloc_data  = mk_instr(32'h500, 5'd0, 1'b0, 1'b1, 1'b0);
    settle();
    tick();
    alloc_data = mk_instr(32'h504, 5'd0, 1'b1, 1'b0, 1'b0);
    settle();
    tick();
    alloc_valid    = 1'b0;
    complete_valid = 1'b1;
    complete_data  = mk_comp(0, 32'h0, 1'b0, 1'b0, 32'h0);
    settle();
    tick();
    complete_data = mk_comp(1, 32'h33, 1'b0, 1'b0, 32'h0);
    settle();
    chk("st_commit", 64'(store_commit), 64'(1'b1));
    chk("st_we", 64'(rf_we), 64'(1'b0));
    tick();
    complete_valid = 1'b0;
    settle();
    chk("x0_valid", 64'(commit_valid), 64'(1'b1));
    chk("x0_we", 64'(rf_we), 64'(1'b0));
    tick();

    // Pre-completed exception at allocation retires one cycle later.
    alloc_valid = 1'b1;
    alloc_data  = mk_instr(32'h600, 5'd3, 1'b1, 1'b0, 1'b1);
    settle();
    tick();
    alloc_valid = 1'b0;
    settle();
    chk("pre_xc_flush", 64'(flush), 64'(1'b1));
    tick();

    // Reset with entries in flight.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      alloc_data  = mk_instr(32'h700 + 32'(i * 4), 5'd9, 1'b1, 1'b0, 1'b0);
      settle();
      tick();
    end
    alloc_valid = 1'b0;
    rst = 1'b1;
    settle();
    tick();
    rst            = 1'b0;
    complete_valid = 1'b1;
    complete_data  = mk_comp(3, 32'h77, 1'b0, 1'b0, 32'h0);
    settle();
    chk("mid_rst_count", 64'(count), 64'(5'd0));
    chk("mid_rst_commit", 64'(commit_valid), 64'(1'b0));
    tick();
    complete_valid = 1'b0;
    settle();
    chk("mid_rst_stale", 64'(commit_valid), 64'(1'b0));
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int cidx;
      rst         = ($urandom_range(0, 299) == 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_data  = mk_instr($urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                             $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      complete_valid = ($urandom_range(0, 9) < 6);
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        cidx = q[$urandom_range(0, q.size() - 1)].idx;
      else
        cidx = int'($urandom_range(0, 15));
      complete_data = mk_comp(cidx, $urandom, $urandom_range(0, 29) == 0,
                              $urandom_range(0, 1) == 1, $urandom);
      settle();
      tick();
    end

    idle_inputs();
    settle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order commit stage for the tartaruga core. Decode allocates an entry per instruction and tags it with `rob_idx`. Writeback marks entries completed out of order. This block retires the oldest completed entry each cycle: it drives the register-file write, releases committed stores, and raises a pipeline flush to `ADDR_XCPT` when a retiring entry carries an exception.

## Interface
Parameters:
- `ROB_SIZE`, default `tartaruga_pkg::ROB_SIZE` (16): number of entries; must be a power of two ≥ 2.

Ports:
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset; synchronous, active-high, sampled on the `clk_i` rising edge.
- `alloc_valid_i`  in  1  decode requests an entry.
- `alloc_data_i`  in  `instr_data_t`  decoded instruction (`pc`, `instr`, `addr_rd`, `write_enable`, `store_to_mem`, `kanata_id`, `xcpt`, `xcpt_code`).
- `alloc_ready_o`  out  1  ROB not full.
- `alloc_idx_o`  out  `rob_idx_t`  index the current allocation receives (the tail).
- `complete_valid_i`  in  1  writeback result valid.
- `complete_data_i`  in  `mem_to_wb_t`  result; target entry is `instr.rob_idx`.
- `commit_valid_o`  out  1  head entry retires this cycle.
- `commit_entry_o`  out  `rob_entry_t`  retiring entry.
- `rf_we_o`  out  1  register-file write enable.
- `rf_addr_o`  out  `reg_addr_t`  destination register.
- `rf_data_o`  out  `bus32_t`  write data.
- `store_commit_o`  out  1  retiring entry is a store; memory may perform it.
- `flush_o`  out  1  exception retire; squash the pipeline.
- `flush_pc_o`  out  `bus32_t`  redirect PC (`ADDR_XCPT`).
- `count_o`  out  `ROB_IDX_BITS+1`  occupied entries.

## Operation
- State: `entries[ROB_SIZE]` of `rob_entry_t`; `head` and `tail` pointers of `ROB_IDX_BITS+1` bits each, where the MSB is the wrap bit; `count = tail - head`.
- Full when `count == ROB_SIZE`; empty when `count == 0`. `alloc_ready_o = !full`, registered-state only, so there is no combinational path from the commit outputs.
- Allocation fires on `alloc_valid_i && alloc_ready_o && !flush_o`:
  - write the entry at `tail`: `valid=1`, `completed=0`, `result=0`, `branch_taken=0`, `new_pc=pc+4`; copy the other fields from `alloc_data_i`;
  - `tail++`.
- Allocation with `xcpt=1` sets `completed=1` immediately, because decode/fetch exceptions have no execution.
- Completion fires on `complete_valid_i`. If `entries[idx].valid && !completed`, it sets:
  - `completed=1`, `result`, `branch_taken`;
  - `new_pc = branched_pc` if taken;
  - `xcpt` and `xcpt_code` OR-merged from `complete_data_i.instr`.
  
  Completion to an invalid or already-completed entry is ignored.
- Commit (combinational from head): `commit_valid_o = entries[head].valid && completed`.
  - No exception: `rf_we_o = write_enable && addr_rd != 0`, `rf_data_o = result`, `store_commit_o = store_to_mem`. At the clock edge: `valid=0`, `head++`.
  - Exception: `rf_we_o=0`, `store_commit_o=0`, `flush_o=1`, `flush_pc_o=ADDR_XCPT`. At the clock edge: all `valid=0`, `head=tail=0`.
- Simultaneous events:
  - alloc + commit in the same cycle: both take effect, and `count` is unchanged.
  - alloc + flush: the alloc is dropped.
  - completion + flush: the completion is dropped.
  - completion to head: commit happens in the following cycle.

## Timing
- Reset values: all `valid=0`, `head=tail=0`. Outputs: `alloc_ready_o=1`, `alloc_idx_o=0`, `commit_valid_o=0`, `rf_we_o=0`, `store_commit_o=0`, `flush_o=0`, `count_o=0`. `flush_pc_o=ADDR_XCPT` (constant).
- Reset asserted mid-operation discards all entries at that edge; reset has priority over every other event.
- Latency:
  - allocation to earliest commit (pre-completed xcpt entry): 1 cycle;
  - completion to commit, when the entry is at the head: 1 cycle.
- Throughput: 1 alloc, 1 completion and 1 commit per cycle.
- Pointer wrap: indices use the low `ROB_IDX_BITS`; the wrap bit disambiguates full from empty.

## Structure
- `rob_entry_t`, `rob_idx_t`, `ROB_SIZE`, `ROB_IDX_BITS`, `ADDR_XCPT` and `mem_to_wb_t` already live in `tartaruga_pkg`.
- Add `rob_ptr_t` (`logic [ROB_IDX_BITS:0]`) to the package so decode can share it.
- No sub-module. Entry storage is flops (one write port for alloc, one for completion, one read port at head), not an SRAM.

## Test plan
- After reset: `alloc_ready_o=1`, `count_o=0`, `commit_valid_o=0`. Allocate `addi x5` (pc 0x100) at idx 0, complete it with result 0x2A, then check the next cycle: `rf_we_o=1`, `rf_addr_o=5`, `rf_data_o=0x2A`, `count_o` returns to 0.
- Allocate idx 0,1,2; complete 2, then 1, then 0. Expect commits in order 0,1,2 on three consecutive cycles, starting one cycle after completion of idx 0.
- Fill 16 entries: `alloc_ready_o=0`, `count_o=16`. Hold `alloc_valid_i`. Complete the head: one commit, `alloc_ready_o=1` the next cycle, and the next allocation gets `alloc_idx_o=0`, wrapped with wrap bit set.
- Allocate 3 entries and complete idx 1 with `xcpt=1`. Idx 0 commits normally. Idx 1 commits with `flush_o=1`, `flush_pc_o=0x2000`, `rf_we_o=0`. Next cycle `count_o=0`, and idx 2 is never committed even if later completed.
- Store with `addr_rd=0` completes: `store_commit_o=1`, `rf_we_o=0`. A write to x0 with `write_enable=1` gives `rf_we_o=0`.
- Assert `rst_i` while 5 entries are in flight: next cycle `count_o=0` and `commit_valid_o=0`, and a completion to old idx 3 is ignored.
